tag_ram_lookup: RTL and testbench
=================================

Name: tag_ram_lookup

Overview:
- Parametrised N-way tag store with per-entry valid bits, a tag-compare lookup port, single-entry invalidate, and a sequenced whole-array flush.
- Successor to the single-way synchronous-read tag RAM. The plain read port is replaced by a hit/miss lookup returning the hit way.
- Sits beside the data RAMs in the cache datapath and is driven by the cache controller.

Parameters:
- AWIDTH, 3, set-index width; DEPTH = 1 << AWIDTH sets.
- TWIDTH, 7, tag width per entry.
- NWAYS, 2, number of ways. Must be ≥ 1. WAYW = max(1, clog2(NWAYS)).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- lk_valid  in  1  lookup request strobe.
- lk_addr  in  AWIDTH  lookup set index.
- lk_tag  in  TWIDTH  tag to compare.
- lk_ready  out  1  lookup accepted; equals ~busy.
- rsp_valid  out  1  response strobe, one cycle after an accepted lookup.
- rsp_hit  out  1  any valid way matched.
- rsp_way  out  WAYW  matching way; lowest index wins.
- rsp_multi  out  1  more than one way matched (error indication).
- wr_en  in  1  tag write strobe.
- wr_addr  in  AWIDTH  write set index.
- wr_way  in  WAYW  write way.
- wr_tag  in  TWIDTH  tag data; the write also sets the valid bit.
- inv_en  in  1  invalidate strobe.
- inv_addr  in  AWIDTH  invalidate set index.
- inv_way  in  WAYW  invalidate way.
- flush_req  in  1  start a full flush; single-cycle pulse.
- busy  out  1  flush in progress.
- flush_done  out  1  one-cycle pulse when a flush completes.

Behaviour:
- Reset, asserted asynchronously:
  - all valid bits = 0; FSM = IDLE; flush counter = 0.
  - rsp_valid, rsp_hit, rsp_multi, rsp_way, busy, flush_done = 0.
  - Tag arrays are not reset; the valid bits mask their contents.
- Tag arrays:
  - one synchronous-write array per way.
  - read address latched on clock; read data is asynchronous from the latched address.
- Lookup:
  - accepted when lk_valid && lk_ready; addr and tag are latched.
  - Cycle N+1: rsp_valid = 1. Per way, hit = valid[way][addr] && tag == latched tag.
  - rsp_hit = OR of per-way hits; rsp_way = lowest hitting way (0 on miss); rsp_multi = popcount > 1.
  - rsp_valid is 0 in any cycle not following an accepted lookup. rsp_hit, rsp_way and rsp_multi are 0 whenever rsp_valid = 0.
- Write/lookup ordering: a write or invalidate in cycle N to the same set as a lookup accepted in cycle N is visible to that lookup's response (write-first).
- Write: when wr_en && ~busy, tag[wr_way][wr_addr] <= wr_tag and valid <= 1. A write while busy is dropped silently.
- Invalidate: when inv_en && ~busy, valid[inv_way][inv_addr] <= 0. Tag is unchanged. Dropped while busy.
- Write and invalidate to the same set/way in the same cycle: invalidate wins (valid = 0); the tag is still written.
- Out-of-range way (wr_way or inv_way ≥ NWAYS): operation ignored.
- Flush FSM:
  - IDLE: flush_req -> FLUSH, counter = 0, busy = 1 from the next cycle.
  - FLUSH: clear valid[all ways][counter]; counter++. After clearing set DEPTH-1 -> IDLE, busy = 0, flush_done = 1 for one cycle.
  - Flush duration is exactly DEPTH cycles of busy.
  - flush_req while busy is ignored (no restart, no queueing).
  - flush_req coincident with wr_en/inv_en in IDLE: the write/invalidate completes this cycle, and the flush clears it later.
- Lookup during flush: lk_ready = 0, request not accepted, no rsp_valid. A lookup accepted in the cycle flush_req arrives still responds normally in the next cycle.
- Reset mid-flush: immediate return to IDLE, busy = 0, no flush_done, all valids 0.
- Counter wraps modulo DEPTH; the terminal test is on DEPTH-1, not on overflow.

Decomposition:
- Package tag_ram_pkg:
  - FSM state enum {IDLE, FLUSH}.
  - WAYW computation function.
  - lookup response struct (hit, way, multi).
- Sub-module tag_ram_way:
  - one way's sync-write, latched-address-read tag array, parameters AWIDTH/TWIDTH.
  - instantiated NWAYS times via generate.
- Valid bits, compare/priority encode, and the flush FSM live in the top.

Test Plan:
- After reset, lookup addr=3 tag=7'h15 -> rsp_valid=1 next cycle, rsp_hit=0, rsp_way=0, rsp_multi=0.
- Write way1 addr=3 tag=7'h15, then lookup addr=3 tag=7'h15 -> hit=1, way=1. Lookup with tag=7'h16 -> hit=0.
- Write way0 addr=5 tag=7'h2A in the same cycle as lookup addr=5 tag=7'h2A -> hit=1, way=0 (write-first). Invalidate way0 addr=5, then lookup -> hit=0.
- Write tag=7'h11 to both ways at addr=2, then lookup -> hit=1, way=0, multi=1. Write+invalidate way1 addr=2 in the same cycle, then lookup -> way=0, multi=0.
- Fill all 8 sets × 2 ways, pulse flush_req:
  - busy high exactly 8 cycles, then flush_done pulses once.
  - lk_ready=0 throughout; a write issued mid-flush is dropped.
  - all subsequent lookups miss.
- Assert reset at flush cycle 4 -> busy=0 immediately, no flush_done; prior entries in sets 4–7 now miss; new flush_req runs a full 8 cycles.

Source files
------------

// File: rtl/tag_ram_pkg.sv
// Shared types and helpers for the N-way tag store: flush FSM states,
// way-index width calculation and the lookup response bundle.
package tag_ram_pkg;

    typedef enum logic {
        IDLE,
        FLUSH
    } flush_state_e;

    localparam int unsigned MAX_WAYW = 8;

    typedef struct packed {
        logic                hit;
        logic [MAX_WAYW-1:0] way;
        logic                multi;
    } lookup_rsp_t;

    function automatic int unsigned calc_wayw(input int unsigned nways);
        if (nways <= 32'd1) return 32'd1;
        return unsigned'($clog2(nways));
    endfunction

endpackage

// File: rtl/tag_ram_way.sv
// One way of the tag store: synchronous write, read address captured on the
// clock and read data driven asynchronously from the captured address.
module tag_ram_way #(
    parameter int unsigned AWIDTH = 3,
    parameter int unsigned TWIDTH = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [TWIDTH-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [TWIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [TWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] raddr_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     raddr_q <= '0;
        else if (re_i) raddr_q <= raddr_i;
    end

    assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/tag_ram_lookup.sv
// N-way tag store with valid bits, one-cycle hit/miss lookup, single-entry
// invalidate and a sequenced flush that clears one set per cycle.
module tag_ram_lookup
    import tag_ram_pkg::*;
#(
    parameter  int unsigned AWIDTH = 3,
    parameter  int unsigned TWIDTH = 7,
    parameter  int unsigned NWAYS  = 2,
    localparam int unsigned WAYW   = calc_wayw(NWAYS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lk_valid,
    input  logic [AWIDTH-1:0] lk_addr,
    input  logic [TWIDTH-1:0] lk_tag,
    output logic              lk_ready,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [WAYW-1:0]   rsp_way,
    output logic              rsp_multi,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [WAYW-1:0]   wr_way,
    input  logic [TWIDTH-1:0] wr_tag,
    input  logic              inv_en,
    input  logic [AWIDTH-1:0] inv_addr,
    input  logic [WAYW-1:0]   inv_way,
    input  logic              flush_req,
    output logic              busy,
    output logic              flush_done
);

    localparam int unsigned DEPTH = 1 << AWIDTH;

    flush_state_e state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic done_q, done_d;
    logic [NWAYS-1:0][DEPTH-1:0] valid_q, valid_d;
    logic [AWIDTH-1:0] lk_addr_q;
    logic [TWIDTH-1:0] lk_tag_q;
    logic rsp_valid_q;
    logic lk_accept, wr_ok, inv_ok;
    logic [TWIDTH-1:0] rd_tag [NWAYS];
    lookup_rsp_t rsp;
    int unsigned hit_cnt;

    assign busy      = (state_q == FLUSH);
    assign lk_ready  = ~busy;
    assign lk_accept = lk_valid & ~busy;
    assign wr_ok     = wr_en & ~busy;
    assign inv_ok    = inv_en & ~busy;

    for (genvar w = 0; w < NWAYS; w++) begin : g_way
        tag_ram_way #(
            .AWIDTH(AWIDTH),
            .TWIDTH(TWIDTH)
        ) u_way (
            .clk_i  (clock),
            .rst_i  (reset),
            .we_i   (wr_ok && (wr_way == WAYW'(w))),
            .waddr_i(wr_addr),
            .wdata_i(wr_tag),
            .re_i   (lk_accept),
            .raddr_i(lk_addr),
            .rdata_o(rd_tag[w])
        );
    end

    // Invalidate is applied after write so it wins on a same-entry collision.
    always_comb begin
        valid_d = valid_q;
        if (state_q == FLUSH) begin
            for (int unsigned w = 0; w < NWAYS; w++) valid_d[w][cnt_q] = 1'b0;
        end else begin
            for (int unsigned w = 0; w < NWAYS; w++) begin
                if (wr_ok && (wr_way == WAYW'(w)))   valid_d[w][wr_addr]  = 1'b1;
                if (inv_ok && (inv_way == WAYW'(w))) valid_d[w][inv_addr] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AWIDTH'(DEPTH - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            valid_q     <= '0;
            lk_addr_q   <= '0;
            lk_tag_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            rsp_valid_q <= lk_accept;
            if (lk_accept) begin
                lk_addr_q <= lk_addr;
                lk_tag_q  <= lk_tag;
            end
        end
    end

    // Arrays and valid bits are read after the accept edge, giving write-first.
    always_comb begin
        rsp     = '0;
        hit_cnt = 0;
        if (rsp_valid_q) begin
            for (int unsigned w = 0; w < NWAYS; w++) begin
                if (valid_q[w][lk_addr_q] && (rd_tag[w] == lk_tag_q)) begin
                    if (!rsp.hit) rsp.way = MAX_WAYW'(w);
                    rsp.hit = 1'b1;
                    hit_cnt = hit_cnt + 1;
                end
            end
            rsp.multi = (hit_cnt > 1);
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp.hit;
    assign rsp_way    = rsp.way[WAYW-1:0];
    assign rsp_multi  = rsp.multi;
    assign flush_done = done_q;

endmodule

// File: tb/tb_tag_ram_lookup.sv
// Self-checking bench for tag_ram_lookup against an array-based reference model.
module tb_tag_ram_lookup;

    localparam int AW    = 3;
    localparam int TW    = 7;
    localparam int NW    = 2;
    localparam int WW    = 1;
    localparam int DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          lk_valid;
    logic [AW-1:0] lk_addr;
    logic [TW-1:0] lk_tag;
    logic          lk_ready;
    logic          rsp_valid;
    logic          rsp_hit;
    logic [WW-1:0] rsp_way;
    logic          rsp_multi;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [WW-1:0] wr_way;
    logic [TW-1:0] wr_tag;
    logic          inv_en;
    logic [AW-1:0] inv_addr;
    logic [WW-1:0] inv_way;
    logic          flush_req;
    logic          busy;
    logic          flush_done;

    always #5 clock = ~clock;

    tag_ram_lookup #(
        .AWIDTH(AW),
        .TWIDTH(TW),
        .NWAYS (NW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .lk_valid  (lk_valid),
        .lk_addr   (lk_addr),
        .lk_tag    (lk_tag),
        .lk_ready  (lk_ready),
        .rsp_valid (rsp_valid),
        .rsp_hit   (rsp_hit),
        .rsp_way   (rsp_way),
        .rsp_multi (rsp_multi),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_way    (wr_way),
        .wr_tag    (wr_tag),
        .inv_en    (inv_en),
        .inv_addr  (inv_addr),
        .inv_way   (inv_way),
        .flush_req (flush_req),
        .busy      (busy),
        .flush_done(flush_done)
    );

    int checks = 0;
    int errors = 0;

    bit            m_valid [NW][DEPTH];
    logic [TW-1:0] m_tag   [NW][DEPTH];
    int            flush_left;
    logic          exp_rv, exp_hit, exp_multi, exp_busy, exp_done;
    logic [WW-1:0] exp_way;

    function automatic logic [TW-1:0] fill_tag(input int w, input int a);
        return TW'(32'h20 + 8 * w + a);
    endfunction

    task automatic idle_inputs();
        lk_valid = 0; lk_addr = '0; lk_tag = '0;
        wr_en = 0; wr_addr = '0; wr_way = '0; wr_tag = '0;
        inv_en = 0; inv_addr = '0; inv_way = '0;
        flush_req = 0;
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++)
            for (int a = 0; a < DEPTH; a++) begin
                m_valid[w][a] = 0;
                m_tag[w][a]   = '0;
            end
        flush_left = 0;
        exp_rv = 0; exp_hit = 0; exp_multi = 0; exp_busy = 0; exp_done = 0; exp_way = '0;
    endtask

    // Advances one clock, updating the model from the inputs presented this cycle.
    task automatic tick();
        logic          acc;
        logic [AW-1:0] a;
        logic [TW-1:0] t;
        int            n;
        acc = lk_valid && (flush_left == 0);
        a   = lk_addr;
        t   = lk_tag;
        if (flush_left > 0) begin
            for (int w = 0; w < NW; w++) m_valid[w][DEPTH - flush_left] = 0;
            flush_left--;
            exp_done = (flush_left == 0);
        end else begin
            exp_done = 0;
            if (wr_en && int'(wr_way) < NW) begin
                m_tag[wr_way][wr_addr]   = wr_tag;
                m_valid[wr_way][wr_addr] = 1;
            end
            if (inv_en && int'(inv_way) < NW) m_valid[inv_way][inv_addr] = 0;
            if (flush_req) flush_left = DEPTH;
        end
        @(posedge clock);
        #1;
        exp_rv = acc; exp_hit = 0; exp_multi = 0; exp_way = '0;
        if (acc) begin
            n = 0;
            for (int w = NW - 1; w >= 0; w--)
                if (m_valid[w][a] && m_tag[w][a] == t) begin
                    n++;
                    exp_way = WW'(w);
                end
            exp_hit   = (n > 0);
            exp_multi = (n > 1);
        end
        exp_busy = (flush_left > 0);
    endtask

    task automatic lookup(input int a, input logic [TW-1:0] t);
        lk_valid = 1; lk_addr = AW'(a); lk_tag = t;
        tick();
        lk_valid = 0;
    endtask

    task automatic write(input int w, input int a, input logic [TW-1:0] t);
        wr_en = 1; wr_way = WW'(w); wr_addr = AW'(a); wr_tag = t;
        tick();
        wr_en = 0;
    endtask

    task automatic fill_all();
        for (int a = 0; a < DEPTH; a++)
            for (int w = 0; w < NW; w++) write(w, a, fill_tag(w, a));
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        reset = 1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", flush_done); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b exp 0", rsp_valid); end
        checks++; if ({rsp_hit, rsp_way, rsp_multi} !== '0) begin errors++; $display("FAIL reset_rsp got %b%b%b exp 000", rsp_hit, rsp_way, rsp_multi); end
        checks++; if (lk_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", lk_ready); end
        reset = 0;
        #2;
    endtask

    task automatic test_miss_after_reset();
        lookup(3, 7'h15);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL miss_rv got %b exp 1", rsp_valid); end
        checks++; if ({rsp_hit, rsp_way, rsp_multi} !== {exp_hit, exp_way, exp_multi} || exp_hit !== 1'b0)
            begin errors++; $display("FAIL miss_rsp got %b%b%b exp %b%b%b", rsp_hit, rsp_way, rsp_multi, exp_hit, exp_way, exp_multi); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || rsp_hit !== 1'b0) begin errors++; $display("FAIL idle_rv got %b/%b exp 0/0", rsp_valid, rsp_hit); end
    endtask

    task automatic test_write_hit();
        write(1, 3, 7'h15);
        lookup(3, 7'h15);
        checks++; if (rsp_hit !== 1'b1 || rsp_way !== 1'b1 || rsp_multi !== 1'b0)
            begin errors++; $display("FAIL wr_hit got hit=%b way=%b multi=%b exp 1/1/0", rsp_hit, rsp_way, rsp_multi); end
        lookup(3, 7'h16);
        checks++; if (rsp_valid !== 1'b1 || rsp_hit !== exp_hit)
            begin errors++; $display("FAIL wr_tagmiss got rv=%b hit=%b exp 1/%b", rsp_valid, rsp_hit, exp_hit); end
    endtask

    task automatic test_write_first();
        wr_en = 1; wr_way = 0; wr_addr = 5; wr_tag = 7'h2A;
        lk_valid = 1; lk_addr = 5; lk_tag = 7'h2A;
        tick();
        idle_inputs();
        checks++; if (rsp_hit !== 1'b1 || rsp_way !== 1'b0 || exp_hit !== 1'b1)
            begin errors++; $display("FAIL write_first got hit=%b way=%b exp 1/0", rsp_hit, rsp_way); end
        inv_en = 1; inv_way = 0; inv_addr = 5;
        tick();
        inv_en = 0;
        lookup(5, 7'h2A);
        checks++; if (rsp_hit !== exp_hit || rsp_valid !== 1'b1)
            begin errors++; $display("FAIL inv_miss got rv=%b hit=%b exp 1/%b", rsp_valid, rsp_hit, exp_hit); end
    endtask

    task automatic test_multi();
        write(0, 2, 7'h11);
        write(1, 2, 7'h11);
        lookup(2, 7'h11);
        checks++; if (rsp_hit !== 1'b1 || rsp_way !== 1'b0 || rsp_multi !== 1'b1)
            begin errors++; $display("FAIL multi got hit=%b way=%b multi=%b exp 1/0/1", rsp_hit, rsp_way, rsp_multi); end
        wr_en = 1; wr_way = 1; wr_addr = 2; wr_tag = 7'h11;
        inv_en = 1; inv_way = 1; inv_addr = 2;
        tick();
        idle_inputs();
        lookup(2, 7'h11);
        checks++; if (rsp_hit !== 1'b1 || rsp_way !== 1'b0 || rsp_multi !== 1'b0 || exp_multi !== 1'b0)
            begin errors++; $display("FAIL inv_wins got hit=%b way=%b multi=%b exp 1/0/0", rsp_hit, rsp_way, rsp_multi); end
    endtask

    task automatic test_flush();
        int busy_cnt, done_cnt;
        fill_all();
        flush_req = 1;
        tick();
        flush_req = 0;
        busy_cnt = 0; done_cnt = 0;
        lk_valid = 1; lk_addr = 0; lk_tag = fill_tag(0, 0);
        for (int c = 0; c < 12; c++) begin
            if (busy === 1'b1) begin
                busy_cnt++;
                checks++; if (lk_ready !== 1'b0) begin errors++; $display("FAIL flush_ready c=%0d got %b exp 0", c, lk_ready); end
            end
            if (flush_done === 1'b1) done_cnt++;
            checks++; if (busy !== exp_busy || flush_done !== exp_done || rsp_valid !== exp_rv || rsp_hit !== exp_hit)
                begin errors++; $display("FAIL flush_cyc c=%0d got busy=%b done=%b rv=%b hit=%b exp %b/%b/%b/%b",
                    c, busy, flush_done, rsp_valid, rsp_hit, exp_busy, exp_done, exp_rv, exp_hit); end
            if (c == 2) begin wr_en = 1; wr_way = 0; wr_addr = 0; wr_tag = fill_tag(0, 0); end
            else wr_en = 0;
            tick();
        end
        idle_inputs();
        checks++; if (busy_cnt !== DEPTH) begin errors++; $display("FAIL flush_len got %0d exp %0d", busy_cnt, DEPTH); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL flush_done_cnt got %0d exp 1", done_cnt); end
        for (int a = 0; a < DEPTH; a++)
            for (int w = 0; w < NW; w++) begin
                lookup(a, fill_tag(w, a));
                checks++; if (rsp_hit !== 1'b0 || exp_hit !== 1'b0)
                    begin errors++; $display("FAIL post_flush a=%0d w=%0d got hit=%b exp 0", a, w, rsp_hit); end
            end
    endtask

    task automatic test_reset_mid_flush();
        int busy_cnt, done_cnt;
        fill_all();
        flush_req = 1;
        tick();
        flush_req = 0;
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midflush_busy got %b exp 1", busy); end
        reset = 1;
        #1;
        checks++; if (busy !== 1'b0 || flush_done !== 1'b0)
            begin errors++; $display("FAIL async_reset got busy=%b done=%b exp 0/0", busy, flush_done); end
        #2;
        reset = 0;
        model_reset();
        tick();
        checks++; if (busy !== 1'b0 || flush_done !== 1'b0)
            begin errors++; $display("FAIL after_reset got busy=%b done=%b exp 0/0", busy, flush_done); end
        for (int a = 4; a < DEPTH; a++)
            for (int w = 0; w < NW; w++) begin
                lookup(a, fill_tag(w, a));
                checks++; if (rsp_valid !== 1'b1 || rsp_hit !== exp_hit)
                    begin errors++; $display("FAIL reset_miss a=%0d w=%0d got rv=%b hit=%b exp 1/%b", a, w, rsp_valid, rsp_hit, exp_hit); end
            end
        flush_req = 1;
        tick();
        flush_req = 0;
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (busy === 1'b1) busy_cnt++;
            if (flush_done === 1'b1) done_cnt++;
            tick();
        end
        checks++; if (busy_cnt !== DEPTH || done_cnt !== 1)
            begin errors++; $display("FAIL reflush got busy=%0d done=%0d exp %0d/1", busy_cnt, done_cnt, DEPTH); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            lk_valid  = 1'($urandom_range(0, 1));
            lk_addr   = AW'($urandom_range(0, DEPTH - 1));
            lk_tag    = TW'($urandom_range(0, 3));
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_way    = WW'($urandom_range(0, NW - 1));
            wr_addr   = AW'($urandom_range(0, DEPTH - 1));
            wr_tag    = TW'($urandom_range(0, 3));
            inv_en    = ($urandom_range(0, 3) == 0);
            inv_way   = WW'($urandom_range(0, NW - 1));
            inv_addr  = AW'($urandom_range(0, DEPTH - 1));
            flush_req = ($urandom_range(0, 60) == 0);
            checks++; if (lk_ready !== (flush_left == 0))
                begin errors++; $display("FAIL rnd_ready i=%0d got %b exp %b", i, lk_ready, flush_left == 0); end
            tick();
            checks++; if ({rsp_valid, rsp_hit, rsp_way, rsp_multi, busy, flush_done} !==
                          {exp_rv, exp_hit, exp_way, exp_multi, exp_busy, exp_done})
                begin errors++; $display("FAIL rnd i=%0d got rv=%b hit=%b way=%b multi=%b busy=%b done=%b exp %b/%b/%b/%b/%b/%b",
                    i, rsp_valid, rsp_hit, rsp_way, rsp_multi, busy, flush_done,
                    exp_rv, exp_hit, exp_way, exp_multi, exp_busy, exp_done); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_miss_after_reset();
        test_write_hit();
        test_write_first();
        test_multi();
        test_flush();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
